// File: rtl/multi_source_probe.sv
// CHANNELS x WIDTH in-system source/probe block with a command/response host port.
// Define SRCPROBE_CHANGE_CNT_EN to add per-channel change counters and the rsp_count port.
module multi_source_probe #(
    parameter int               CHANNELS     = 4,
    parameter int               WIDTH        = 32,
    parameter int               SYNC_STAGES  = 2,
    parameter logic [WIDTH-1:0] SOURCE_INIT  = '0,
    parameter int               PULSE_CYCLES = 4,
    localparam int              CW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      source_clk,
    input  logic                      source_rst,
    input  logic [CHANNELS*WIDTH-1:0] probe,
    output logic [CHANNELS*WIDTH-1:0] source,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [CW-1:0]             cmd_chan,
    input  logic [WIDTH-1:0]          cmd_wdata,
    output logic                      rsp_valid,
    output logic [WIDTH-1:0]          rsp_data,
`ifdef SRCPROBE_CHANGE_CNT_EN
    output logic [15:0]               rsp_count,
`endif
    output logic                      busy
);

    localparam int PCW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESP  = 2'd1,
        PULSE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] source_reg [CHANNELS];
    logic [WIDTH-1:0] sync_probe [CHANNELS];
    logic [WIDTH-1:0] sticky_w   [CHANNELS];
    logic [CHANNELS-1:0] clear_sel;
    logic             accept;

    logic [WIDTH-1:0] saved_reg;
    logic [WIDTH-1:0] pulse_data_reg;
    logic [CW-1:0]    pulse_chan_reg;
    logic [PCW-1:0]   count_reg;

    logic [WIDTH-1:0] rd_probe;
    logic [WIDTH-1:0] rd_sticky;
    logic [WIDTH-1:0] rd_source;

    assign cmd_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign accept    = cmd_valid && (state_reg == IDLE);

`ifdef SRCPROBE_CHANGE_CNT_EN
    logic [15:0] cnt_w [CHANNELS];
    logic [15:0] rd_cnt;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [WIDTH-1:0] stage_reg [SYNC_STAGES];
            logic [WIDTH-1:0] prev_reg;
            logic [WIDTH-1:0] sticky_reg;
            logic [WIDTH-1:0] change;

            assign sync_probe[gi] = stage_reg[SYNC_STAGES-1];
            assign change         = sync_probe[gi] ^ prev_reg;
            assign sticky_w[gi]   = sticky_reg;
            assign clear_sel[gi]  = accept && (cmd_op == 2'b11) && (cmd_chan == CW'(gi));
            assign source[gi*WIDTH +: WIDTH] = source_reg[gi];

            always_ff @(posedge source_clk or posedge source_rst) begin
                if (source_rst) begin
                    for (int s = 0; s < SYNC_STAGES; s++) stage_reg[s] <= '0;
                    prev_reg   <= '0;
                    sticky_reg <= '0;
                end else begin
                    stage_reg[0] <= probe[gi*WIDTH +: WIDTH];
                    for (int s = 1; s < SYNC_STAGES; s++) stage_reg[s] <= stage_reg[s-1];
                    prev_reg <= sync_probe[gi];
                    // A change landing on the clear edge survives the clear.
                    sticky_reg <= (clear_sel[gi] ? '0 : sticky_reg) | change;
                end
            end

`ifdef SRCPROBE_CHANGE_CNT_EN
            logic [15:0] cnt_reg;
            assign cnt_w[gi] = cnt_reg;

            always_ff @(posedge source_clk or posedge source_rst) begin
                if (source_rst) begin
                    cnt_reg <= '0;
                end else if (clear_sel[gi]) begin
                    cnt_reg <= {15'd0, |change};
                end else if ((|change) && (cnt_reg != 16'hFFFF)) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
`endif
        end
    endgenerate

    // Unmatched channel numbers leave every read at zero.
    always_comb begin
        rd_probe  = '0;
        rd_sticky = '0;
        rd_source = '0;
`ifdef SRCPROBE_CHANGE_CNT_EN
        rd_cnt    = '0;
`endif
        for (int c = 0; c < CHANNELS; c++) begin
            if (cmd_chan == CW'(c)) begin
                rd_probe  = sync_probe[c];
                rd_sticky = sticky_w[c];
                rd_source = source_reg[c];
`ifdef SRCPROBE_CHANGE_CNT_EN
                rd_cnt    = cnt_w[c];
`endif
            end
        end
    end

    always_ff @(posedge source_clk or posedge source_rst) begin
        if (source_rst) begin
            state_reg      <= IDLE;
            for (int c = 0; c < CHANNELS; c++) source_reg[c] <= SOURCE_INIT;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            saved_reg      <= '0;
            pulse_data_reg <= '0;
            pulse_chan_reg <= '0;
            count_reg      <= '0;
`ifdef SRCPROBE_CHANGE_CNT_EN
            rsp_count      <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            2'b00: begin
                                rsp_data  <= rd_probe;
                                state_reg <= RESP;
                            end
                            2'b01: begin
                                for (int c = 0; c < CHANNELS; c++)
                                    if (cmd_chan == CW'(c)) source_reg[c] <= cmd_wdata;
                                rsp_data  <= cmd_wdata;
                                state_reg <= RESP;
                            end
                            2'b10: begin
                                for (int c = 0; c < CHANNELS; c++)
                                    if (cmd_chan == CW'(c)) source_reg[c] <= cmd_wdata;
                                saved_reg      <= rd_source;
                                pulse_chan_reg <= cmd_chan;
                                pulse_data_reg <= cmd_wdata;
                                count_reg      <= PCW'(PULSE_CYCLES - 1);
                                state_reg      <= PULSE;
                            end
                            default: begin
                                rsp_data  <= rd_sticky;
`ifdef SRCPROBE_CHANGE_CNT_EN
                                rsp_count <= rd_cnt;
`endif
                                state_reg <= RESP;
                            end
                        endcase
                    end
                end
                PULSE: begin
                    if (count_reg == '0) begin
                        for (int c = 0; c < CHANNELS; c++)
                            if (pulse_chan_reg == CW'(c)) source_reg[c] <= saved_reg;
                        rsp_data  <= pulse_data_reg;
                        state_reg <= RESP;
                    end else begin
                        count_reg <= count_reg - PCW'(1);
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
